// File: rtl/controle_jogo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : controle_jogo                                                |
// | Description : Game-flow sequencer for the ship-shooter. Owns the game      |
// |               state, lives, BCD score, frame-paced entity step and blink.  |
// |               Optional: CONTROLE_JOGO_RECORDE_EN builds the BCD high score.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module controle_jogo #(
    parameter int VIDAS_INICIAIS = 3,
    parameter int QUADROS_INVULN = 60,
    parameter int PONTOS_ACERTO  = 1,
    parameter int PERIODO_PISCA  = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pausa,
    input  logic        hit_nave,
    input  logic        hit_inimigo,
    output logic [2:0]  estado,
    output logic [1:0]  vidas,
    output logic [15:0] pontos,
    output logic        passo,
    output logic        respawn,
    output logic        perdeu,
    output logic        piscar,
    output logic [15:0] recorde
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_JOGANDO  = 3'd1;
    localparam logic [2:0] c_PAUSA    = 3'd2;
    localparam logic [2:0] c_ATINGIDO = 3'd3;
    localparam logic [2:0] c_FIM      = 3'd4;

    localparam logic [1:0] c_VIDAS      = 2'(VIDAS_INICIAIS);
    localparam logic [7:0] c_QUADROS    = 8'(QUADROS_INVULN);
    localparam logic [7:0] c_PISCA_ULT  = 8'(PERIODO_PISCA - 1);
    localparam logic [3:0] c_INCREMENTO = 4'(PONTOS_ACERTO);

    logic [2:0]  r_estado;
    logic [1:0]  r_vidas;
    logic [15:0] r_pontos;
    logic        r_passo;
    logic        r_respawn;
    logic        r_perdeu;
    logic        r_piscar;
    logic [7:0]  r_cnt;
    logic [7:0]  r_pisca_cnt;
    logic        r_volta;

    logic [2:0]  w_estado;
    logic [1:0]  w_vidas;
    logic [15:0] w_pontos;
    logic [15:0] w_soma;
    logic        w_respawn;
    logic        w_piscar;
    logic [7:0]  w_cnt;
    logic [7:0]  w_pisca_cnt;
    logic        w_volta;
    logic        w_passo;

    // Digit-serial BCD add; any carry out of the top digit saturates at 9999.
    function automatic logic [15:0] f_bcd_soma(input logic [15:0] val, input logic [3:0] inc);
        logic [15:0] res;
        logic [4:0]  dig;
        logic [4:0]  carry;
        res   = '0;
        carry = {1'b0, inc};
        for (int i = 0; i < 4; i++) begin
            dig = {1'b0, val[i*4 +: 4]} + carry;
            if (dig > 5'd9) begin
                res[i*4 +: 4] = 4'(dig - 5'd10);
                carry         = 5'd1;
            end else begin
                res[i*4 +: 4] = dig[3:0];
                carry         = 5'd0;
            end
        end
        if (carry != 5'd0) begin
            res = 16'h9999;
        end
        return res;
    endfunction

    assign w_soma = f_bcd_soma(r_pontos, c_INCREMENTO);

    always_comb begin
        w_estado    = r_estado;
        w_vidas     = r_vidas;
        w_pontos    = r_pontos;
        w_respawn   = 1'b0;
        w_piscar    = r_piscar;
        w_cnt       = r_cnt;
        w_pisca_cnt = r_pisca_cnt;
        w_volta     = r_volta;
        case (r_estado)
            c_IDLE: begin
                if (start) begin
                    w_estado  = c_JOGANDO;
                    w_vidas   = c_VIDAS;
                    w_pontos  = '0;
                    w_respawn = 1'b1;
                end
            end
            c_JOGANDO: begin
                if (hit_inimigo) begin
                    w_pontos = w_soma;
                end
                // A ship hit wins over a pause request in the same cycle so it is never lost.
                if (hit_nave) begin
                    if (r_vidas > 2'd1) begin
                        w_vidas     = r_vidas - 2'd1;
                        w_estado    = c_ATINGIDO;
                        w_cnt       = '0;
                        w_pisca_cnt = '0;
                        w_piscar    = 1'b1;
                    end else begin
                        w_vidas  = '0;
                        w_estado = c_FIM;
                    end
                end else if (pausa) begin
                    w_estado = c_PAUSA;
                    w_volta  = 1'b0;
                end
            end
            c_ATINGIDO: begin
                if (hit_inimigo) begin
                    w_pontos = w_soma;
                end
                if (pausa) begin
                    w_estado = c_PAUSA;
                    w_volta  = 1'b1;
                end else if (frame_tick) begin
                    if (r_cnt + 8'd1 == c_QUADROS) begin
                        w_estado = c_JOGANDO;
                        w_cnt    = '0;
                        w_piscar = 1'b0;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                        if (r_pisca_cnt == c_PISCA_ULT) begin
                            w_pisca_cnt = '0;
                            w_piscar    = ~r_piscar;
                        end else begin
                            w_pisca_cnt = r_pisca_cnt + 8'd1;
                        end
                    end
                end
            end
            c_PAUSA: begin
                if (!pausa) begin
                    w_estado = r_volta ? c_ATINGIDO : c_JOGANDO;
                end
            end
            c_FIM: begin
                if (start) begin
                    w_estado = c_IDLE;
                    w_pontos = '0;
                    w_vidas  = '0;
                end
            end
            default: begin
                w_estado = c_IDLE;
                w_piscar = 1'b0;
            end
        endcase
        // Step is judged against the state being entered, so it never shows up beside PAUSA/FIM.
        w_passo = frame_tick && ((w_estado == c_JOGANDO) || (w_estado == c_ATINGIDO));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_estado    <= c_IDLE;
            r_vidas     <= '0;
            r_pontos    <= '0;
            r_passo     <= 1'b0;
            r_respawn   <= 1'b0;
            r_perdeu    <= 1'b0;
            r_piscar    <= 1'b0;
            r_cnt       <= '0;
            r_pisca_cnt <= '0;
            r_volta     <= 1'b0;
        end else begin
            r_estado    <= w_estado;
            r_vidas     <= w_vidas;
            r_pontos    <= w_pontos;
            r_passo     <= w_passo;
            r_respawn   <= w_respawn;
            r_perdeu    <= (w_estado == c_FIM);
            r_piscar    <= w_piscar;
            r_cnt       <= w_cnt;
            r_pisca_cnt <= w_pisca_cnt;
            r_volta     <= w_volta;
        end
    end

`ifdef CONTROLE_JOGO_RECORDE_EN
    logic [15:0] r_recorde;

    // Valid BCD orders like binary, so a plain magnitude compare suffices.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_recorde <= '0;
        end else if ((w_estado == c_FIM) && (r_estado != c_FIM) && (w_pontos > r_recorde)) begin
            r_recorde <= w_pontos;
        end
    end

    assign recorde = r_recorde;
`else
    assign recorde = 16'h0000;
`endif

    assign estado  = r_estado;
    assign vidas   = r_vidas;
    assign pontos  = r_pontos;
    assign passo   = r_passo;
    assign respawn = r_respawn;
    assign perdeu  = r_perdeu;
    assign piscar  = r_piscar;

endmodule
`default_nettype wire

// File: tb/tb_controle_jogo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_controle_jogo                                             |
// | Description : Scoreboard bench for controle_jogo against a decimal-level   |
// |               game model; directed scenarios followed by random play.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_controle_jogo;

    localparam int c_VIDAS   = 3;
    localparam int c_QUADROS = 4;
    localparam int c_PONTOS  = 1;
    localparam int c_PERIODO = 2;

    logic clk = 1'b0;
    logic r_reset = 1'b0, r_frame_tick = 1'b0, r_start = 1'b0, r_pausa = 1'b0;
    logic r_hit_nave = 1'b0, r_hit_inimigo = 1'b0;
    wire logic [2:0]  w_estado;
    wire logic [1:0]  w_vidas;
    wire logic [15:0] w_pontos;
    wire logic        w_passo, w_respawn, w_perdeu, w_piscar;
    wire logic [15:0] w_recorde;

    controle_jogo #(
        .VIDAS_INICIAIS(c_VIDAS),
        .QUADROS_INVULN(c_QUADROS),
        .PONTOS_ACERTO (c_PONTOS),
        .PERIODO_PISCA (c_PERIODO)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (r_reset),
        .frame_tick (r_frame_tick),
        .start      (r_start),
        .pausa      (r_pausa),
        .hit_nave   (r_hit_nave),
        .hit_inimigo(r_hit_inimigo),
        .estado     (w_estado),
        .vidas      (w_vidas),
        .pontos     (w_pontos),
        .passo      (w_passo),
        .respawn    (w_respawn),
        .perdeu     (w_perdeu),
        .piscar     (w_piscar),
        .recorde    (w_recorde)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  estado;
        logic [1:0]  vidas;
        logic [15:0] pontos;
        logic        passo;
        logic        respawn;
        logic        perdeu;
        logic        piscar;
        logic [15:0] recorde;
    } saida_t;

    saida_t q_esperado[$];
    string  q_nome[$];
    int     total = 0;
    int     bad   = 0;
    string  fase  = "reset";

    // Game model: plain integers, score kept in decimal.
    int m_est = 0, m_vidas = 0, m_score = 0, m_frames = 0, m_rec = 0;
    bit m_volta = 1'b0;

    function automatic logic [15:0] para_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic ciclo(input bit st, input bit pa, input bit hn, input bit hi,
                         input bit ft, input bit rs);
        saida_t e;
        bit     resp;
        int     ant;
        @(negedge clk);
        r_start = st; r_pausa = pa; r_hit_nave = hn; r_hit_inimigo = hi;
        r_frame_tick = ft; r_reset = rs;
        resp = 1'b0;
        if (rs) begin
            m_est = 0; m_vidas = 0; m_score = 0; m_frames = 0; m_volta = 1'b0; m_rec = 0;
        end else begin
            ant = m_est;
            if (hi && (m_est == 1 || m_est == 3)) begin
                m_score = (m_score + c_PONTOS > 9999) ? 9999 : m_score + c_PONTOS;
            end
            case (m_est)
                0: if (st) begin m_est = 1; m_vidas = c_VIDAS; m_score = 0; resp = 1'b1; end
                1: begin
                    if (hn) begin
                        if (m_vidas > 1) begin m_vidas--; m_est = 3; m_frames = 0; end
                        else begin m_vidas = 0; m_est = 4; end
                    end else if (pa) begin
                        m_est = 2; m_volta = 1'b0;
                    end
                end
                3: begin
                    if (pa) begin
                        m_est = 2; m_volta = 1'b1;
                    end else if (ft) begin
                        m_frames++;
                        if (m_frames == c_QUADROS) m_est = 1;
                    end
                end
                2: if (!pa) m_est = m_volta ? 3 : 1;
                4: if (st) begin m_est = 0; m_score = 0; m_vidas = 0; end
                default: m_est = 0;
            endcase
`ifdef CONTROLE_JOGO_RECORDE_EN
            if (m_est == 4 && ant != 4 && m_score > m_rec) m_rec = m_score;
`endif
        end
        e.estado  = 3'(m_est);
        e.vidas   = 2'(m_vidas);
        e.pontos  = para_bcd(m_score);
        e.passo   = !rs && ft && (m_est == 1 || m_est == 3);
        e.respawn = resp;
        e.perdeu  = (m_est == 4);
        e.piscar  = (m_est == 3 || (m_est == 2 && m_volta)) && (((m_frames / c_PERIODO) % 2) == 0);
        e.recorde = para_bcd(m_rec);
        q_esperado.push_back(e);
        q_nome.push_back(fase);
    endtask

    task automatic ocioso(input int n);
        repeat (n) ciclo(0, 0, 0, 0, 0, 0);
    endtask

    // Full game: start, n enemy hits, then lose every life with invulnerability windows in between.
    task automatic jogo(input int n);
        ciclo(1, 0, 0, 0, 0, 0);
        repeat (n) ciclo(0, 0, 0, 1, 0, 0);
        repeat (c_VIDAS) begin
            ciclo(0, 0, 1, 0, 0, 0);
            repeat (c_QUADROS) ciclo(0, 0, 0, 0, 1, 0);
        end
        ocioso(2);
        ciclo(1, 0, 0, 0, 0, 0);
        ocioso(1);
    endtask

    always @(posedge clk) begin
        #1;
        if (q_esperado.size() != 0) begin
            saida_t exp_v;
            saida_t obt;
            string  nome;
            exp_v = q_esperado.pop_front();
            nome  = q_nome.pop_front();
            obt   = {w_estado, w_vidas, w_pontos, w_passo, w_respawn, w_perdeu, w_piscar, w_recorde};
            total++;
            if (obt !== exp_v) begin
                bad++;
                $display("FAIL %s t=%0t got estado=%0d vidas=%0d pontos=%h passo=%b respawn=%b perdeu=%b piscar=%b recorde=%h | exp estado=%0d vidas=%0d pontos=%h passo=%b respawn=%b perdeu=%b piscar=%b recorde=%h",
                         nome, $time, obt.estado, obt.vidas, obt.pontos, obt.passo, obt.respawn,
                         obt.perdeu, obt.piscar, obt.recorde, exp_v.estado, exp_v.vidas,
                         exp_v.pontos, exp_v.passo, exp_v.respawn, exp_v.perdeu, exp_v.piscar,
                         exp_v.recorde);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", q_esperado.size());
        $fatal(1, "time limit");
    end

    initial begin
        bit pa;
        repeat (3) ciclo(0, 0, 0, 0, 0, 1);
        ocioso(2);

        fase = "inicio";
        ciclo(1, 0, 0, 0, 0, 0);
        ocioso(2);

        fase = "passo";
        repeat (3) begin
            ciclo(0, 0, 0, 0, 1, 0);
            ciclo(0, 0, 0, 0, 0, 0);
        end

        fase = "pausa";
        ciclo(0, 1, 0, 0, 0, 0);
        repeat (2) ciclo(0, 1, 0, 0, 1, 0);
        ciclo(1, 1, 1, 1, 0, 0);
        ciclo(0, 0, 0, 0, 0, 0);
        ocioso(1);

        fase = "pontos";
        repeat (100) ciclo(0, 0, 0, 1, 0, 0);

        fase = "nave";
        ciclo(0, 0, 1, 0, 0, 0);
        ciclo(0, 0, 1, 0, 1, 0);
        ciclo(1, 0, 0, 0, 1, 0);
        ciclo(0, 1, 0, 0, 1, 0);
        ciclo(0, 1, 0, 1, 0, 0);
        ciclo(0, 0, 0, 0, 0, 0);
        repeat (3) ciclo(0, 0, 0, 0, 1, 0);
        ocioso(1);
        ciclo(0, 0, 1, 0, 0, 0);
        repeat (c_QUADROS) ciclo(0, 0, 0, 0, 1, 0);

        fase = "fim";
        ciclo(0, 0, 1, 1, 0, 0);
        ciclo(0, 0, 0, 0, 1, 0);
        ciclo(1, 0, 0, 0, 0, 0);
        ocioso(1);

        fase = "recorde";
        jogo(12);
        jogo(5);

        fase = "reset_meio";
        ciclo(1, 0, 0, 0, 0, 0);
        repeat (5) ciclo(0, 0, 0, 1, 1, 0);
        ciclo(0, 0, 1, 1, 1, 1);
        ocioso(2);

        fase = "saturacao";
        ciclo(1, 0, 0, 0, 0, 0);
        repeat (10002) ciclo(0, 0, 0, 1, 0, 0);
        ciclo(0, 0, 1, 1, 1, 0);
        ciclo(0, 0, 0, 0, 0, 1);

        fase = "aleatorio";
        pa = 1'b0;
        repeat (3000) begin
            if (pa) pa = ($urandom_range(0, 3) != 0);
            else    pa = ($urandom_range(0, 14) == 0);
            ciclo($urandom_range(0, 19) == 0, pa, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 299) == 0);
        end
        ocioso(3);

        @(negedge clk);
        r_start = 0; r_pausa = 0; r_hit_nave = 0; r_hit_inimigo = 0; r_frame_tick = 0; r_reset = 0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q_esperado.size() != 0) begin
            bad++;
            $display("FAIL drenagem: pending=%0d required=0", q_esperado.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
